servo_pwm_multi: RTL

//  N-channel hobby-servo PWM generator sharing one frame counter. Successor to the single-channel driver:

---
 rtl/servo_pkg.sv | 33 +++
 rtl/servo_slew_ch.sv | 100 ++++++++++
 rtl/servo_pwm_multi.sv | 93 +++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared helpers for the servo PWM drivers: pulse-width arithmetic,
// counter/index widths and the parameter-legality check.
`define SERVO_PARAM_CHECK(ok_expr) if (!(ok_expr)) begin : g_illegal_params $error("servo_pwm: illegal parameter set"); end

package servo_pkg;

  function automatic int calc_delta(input int pulse_min, input int pulse_max, input int angle_max);
    return (pulse_max - pulse_min) / angle_max;
  endfunction

  function automatic int angle_to_cnt(input int angle, input int pulse_min, input int pulse_max,
                                      input int angle_max);
    return pulse_min + angle * calc_delta(pulse_min, pulse_max, angle_max);
  endfunction

  function automatic int cnt_width(input int period_cnt);
    return $clog2(period_cnt) + 1;
  endfunction

  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // The last staggered pulse must finish inside the frame.
  function automatic bit params_legal(input int n_ch, input int period_cnt, input int pulse_min,
                                      input int pulse_max, input int angle_max, input int stagger_cnt,
                                      input int init_angle);
    return (n_ch >= 1) && (n_ch <= 16) && (angle_max >= 1) && (angle_max <= 255) &&
           (init_angle <= angle_max) && (pulse_min <= pulse_max) &&
           ((n_ch - 1) * stagger_cnt + pulse_max <= period_cnt);
  endfunction

endpackage

// File: rtl/servo_slew_ch.sv
// One servo channel: target/current angle, slew limiter, per-frame width
// latch and the staggered pulse compare against the shared frame counter.
module servo_slew_ch
  import servo_pkg::*;
#(
  parameter int CNT_W      = 21,
  parameter int PULSE_MIN  = 25_000,
  parameter int PULSE_MAX  = 125_000,
  parameter int ANGLE_MAX  = 180,
  parameter int STEP_DEG   = 2,
  parameter int INIT_ANGLE = 90,
  parameter int OFFSET     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic             boundary,
  input  logic             en_q,
  input  logic             wr_en,
  input  logic [7:0]       wr_angle,
  output logic             pwm,
  output logic             at_target
);

  localparam logic [7:0]       AMAX_L  = 8'(ANGLE_MAX);
  localparam logic [7:0]       STEP_L  = 8'(STEP_DEG);
  localparam logic [7:0]       INIT_L  = 8'(INIT_ANGLE);
  localparam logic [CNT_W-1:0] OFF_L   = CNT_W'(OFFSET);
  localparam logic [CNT_W-1:0] PMIN_L  = CNT_W'(PULSE_MIN);
  localparam logic [CNT_W-1:0] DELTA_L = CNT_W'(calc_delta(PULSE_MIN, PULSE_MAX, ANGLE_MAX));
  localparam logic [CNT_W-1:0] INIT_W  = CNT_W'(angle_to_cnt(INIT_ANGLE, PULSE_MIN, PULSE_MAX, ANGLE_MAX));

  logic [7:0]       tgt_r, cur_r, clamp_s, cur_next_s, diff_s;
  logic [CNT_W-1:0] width_r, width_next_s, end_s;
  logic             lo_ok_s, pwm_r;

  // Clamp incoming target to the legal angle range.
  always_comb begin
    if (wr_angle > AMAX_L) begin
      clamp_s = AMAX_L;
    end else begin
      clamp_s = wr_angle;
    end
  end

  // Next current angle: held while disabled, else one bounded step toward target.
  always_comb begin
    cur_next_s = cur_r;
    diff_s     = 8'd0;
    if (!en_q) begin
      cur_next_s = cur_r;
    end else if (tgt_r >= cur_r) begin
      diff_s = tgt_r - cur_r;
      if ((STEP_DEG == 0) || (diff_s <= STEP_L)) begin
        cur_next_s = tgt_r;
      end else begin
        cur_next_s = cur_r + STEP_L;
      end
    end else begin
      diff_s = cur_r - tgt_r;
      if ((STEP_DEG == 0) || (diff_s <= STEP_L)) begin
        cur_next_s = tgt_r;
      end else begin
        cur_next_s = cur_r - STEP_L;
      end
    end
  end

  assign width_next_s = PMIN_L + CNT_W'(cur_next_s) * DELTA_L;
  assign end_s        = OFF_L + width_r;

  if (OFFSET == 0) begin : g_no_off
    assign lo_ok_s = 1'b1;
  end else begin : g_off
    assign lo_ok_s = (cnt >= OFF_L);
  end

  // Angle registers, per-frame width latch and registered pulse output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_r   <= INIT_L;
      cur_r   <= INIT_L;
      width_r <= INIT_W;
      pwm_r   <= 1'b0;
    end else begin
      if (wr_en) begin
        tgt_r <= clamp_s;
      end
      if (boundary) begin
        cur_r   <= cur_next_s;
        width_r <= width_next_s;
      end
      pwm_r <= en_q && lo_ok_s && (cnt < end_s);
    end
  end

  assign pwm       = pwm_r;
  assign at_target = (cur_r == tgt_r);

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM generator: shared frame counter, frame-latched enable,
// valid/ready target commands and one slew-limited channel per output.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int PERIOD_CNT  = 1_000_000,
  parameter int PULSE_MIN   = 25_000,
  parameter int PULSE_MAX   = 125_000,
  parameter int ANGLE_MAX   = 180,
  parameter int STEP_DEG    = 2,
  parameter int STAGGER_CNT = 130_000,
  parameter int INIT_ANGLE  = 90
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ch_width(N_CH)-1:0] cmd_ch,
  input  logic [7:0]                cmd_angle,
  output logic [N_CH-1:0]           pwm,
  output logic [N_CH-1:0]           at_target,
  output logic                      frame_tick
);

  localparam int               CNT_W  = cnt_width(PERIOD_CNT);
  localparam int               CH_W   = ch_width(N_CH);
  localparam logic [CNT_W-1:0] LAST_L = CNT_W'(PERIOD_CNT - 1);
  localparam logic [CH_W:0]    NCH_L  = (CH_W + 1)'(N_CH);

  `SERVO_PARAM_CHECK(params_legal(N_CH, PERIOD_CNT, PULSE_MIN, PULSE_MAX, ANGLE_MAX, STAGGER_CNT, INIT_ANGLE))

  logic [CNT_W-1:0] cnt_r;
  logic             boundary_s, en_q_r, frame_tick_r, armed_r, ch_ok_s, accept_s;

  assign boundary_s = (cnt_r == LAST_L);

  // Free-running frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (boundary_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // Frame-latched enable, frame tick and post-reset command arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q_r       <= 1'b0;
      frame_tick_r <= 1'b0;
      armed_r      <= 1'b0;
    end else begin
      if (boundary_s) begin
        en_q_r <= enable;
      end
      frame_tick_r <= boundary_s;
      armed_r      <= 1'b1;
    end
  end

  // An out-of-range channel is stalled rather than dropped.
  assign ch_ok_s    = ({1'b0, cmd_ch} < NCH_L);
  assign cmd_ready  = armed_r && ch_ok_s;
  assign accept_s   = cmd_valid && cmd_ready;
  assign frame_tick = frame_tick_r;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    servo_slew_ch #(
      .CNT_W      (CNT_W),
      .PULSE_MIN  (PULSE_MIN),
      .PULSE_MAX  (PULSE_MAX),
      .ANGLE_MAX  (ANGLE_MAX),
      .STEP_DEG   (STEP_DEG),
      .INIT_ANGLE (INIT_ANGLE),
      .OFFSET     (k * STAGGER_CNT)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .cnt       (cnt_r),
      .boundary  (boundary_s),
      .en_q      (en_q_r),
      .wr_en     (accept_s && (cmd_ch == CH_W'(k))),
      .wr_angle  (cmd_angle),
      .pwm       (pwm[k]),
      .at_target (at_target[k])
    );
  end

endmodule
